// File: rtl/ins_seq.sv
// Instruction sequencer for the cryptoprocessor datapath: accepts one instruction at a
// time, drives RAM read/write addresses and the operand-select mux, and waits out ALU/MUL latency.
module ins_seq #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ins_valid,
  output logic                    ins_ready,
  input  logic [3+3*ADDR_W-1:0]   ins_word,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic                    mul_start,
  input  logic                    mul_done,
  output logic [ADDR_W-1:0]       addra,
  output logic [ADDR_W-1:0]       addrb,
  output logic [ADDR_W-1:0]       addrw,
  output logic                    we,
  output logic                    d_in,
  output logic [2:0]              INS,
  output logic                    busy,
  output logic                    err
);

  typedef enum logic [2:0] {
    S_IDLE, S_DIN, S_RD, S_EX, S_WB
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_MOV  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_MUL  = 3'd5,
    OP_ILL6 = 3'd6,
    OP_ILL7 = 3'd7
  } op_t;

  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  state_t              state, state_nx;
  op_t                 op_q;
  logic [ADDR_W-1:0]   dst_q, srca_q, srcb_q;
  logic [3:0]          cnt, cnt_nx;
  logic                err_q;
  op_t                 ins_op;
  logic                accept;
  logic                latch_fields;

  assign ins_op       = op_t'(ins_word[3+3*ADDR_W-1 -: 3]);
  assign accept       = ins_valid && ins_ready;
  assign latch_fields = accept && (ins_op inside {OP_LOAD, OP_MOV, OP_ADD, OP_SUB, OP_MUL});

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (ins_op)
            OP_LOAD:                        state_nx = S_DIN;
            OP_MOV, OP_ADD, OP_SUB, OP_MUL: state_nx = S_RD;
            default:                        state_nx = S_IDLE;
          endcase
        end
      end
      S_DIN: if (din_valid) state_nx = S_WB;
      S_RD: begin
        state_nx = S_EX;
        cnt_nx   = '0;
      end
      S_EX: begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            if (cnt == LAT_LAST) state_nx = S_WB;
            else                 cnt_nx   = cnt + 4'd1;
          end
          OP_MUL: begin
            // cnt marks "start already issued" so mul_start pulses only once
            cnt_nx = 4'd1;
            if (mul_done) state_nx = S_WB;
          end
          default: state_nx = S_WB;
        endcase
      end
      S_WB:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= OP_NOP;
      dst_q  <= '0;
      srca_q <= '0;
      srcb_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (latch_fields) begin
        op_q   <= ins_op;
        dst_q  <= ins_word[3*ADDR_W-1 -: ADDR_W];
        srca_q <= ins_word[2*ADDR_W-1 -: ADDR_W];
        srcb_q <= ins_word[ADDR_W-1:0];
      end
      if (accept && (ins_op == OP_ILL6 || ins_op == OP_ILL7)) err_q <= 1'b1;
    end
  end

  always_comb begin
    INS  = 3'd0;
    d_in = 1'b0;
    case (state)
      S_DIN: begin
        INS  = 3'd1;
        d_in = 1'b1;
      end
      S_RD, S_EX: INS = op_q;
      S_WB: begin
        INS  = op_q;
        d_in = (op_q == OP_LOAD);
      end
      default: ;
    endcase
  end

  assign ins_ready = (state == S_IDLE) && rst_n;
  assign din_ready = (state == S_DIN);
  assign busy      = (state != S_IDLE);
  assign we        = (state == S_WB);
  assign mul_start = (state == S_EX) && (op_q == OP_MUL) && (cnt == 4'd0);
  assign addra     = srca_q;
  assign addrb     = srcb_q;
  assign addrw     = dst_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ins_seq.sv
// Directed bench for ins_seq: two instances (ALU_LAT=2 and ALU_LAT=4) share stimulus;
// a vector table covers each opcode, followed by hand sequences for illegal ops and reset.
module tb_ins_seq;
  localparam int W  = 6;
  localparam int IW = 3 + 3*W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ins_valid = 1'b0;
  logic din_valid = 1'b0;
  logic mul_done = 1'b0;
  logic [IW-1:0] ins_word = '0;

  logic ins_ready_a, din_ready_a, mul_start_a, we_a, d_in_a, busy_a, err_a;
  logic [W-1:0] addra_a, addrb_a, addrw_a;
  logic [2:0] ins_a;
  logic ins_ready_b, din_ready_b, mul_start_b, we_b, d_in_b, busy_b, err_b;
  logic [W-1:0] addra_b, addrb_b, addrw_b;
  logic [2:0] ins_b;

  ins_seq #(.ADDR_W(W), .ALU_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(ins_ready_a),
    .ins_word(ins_word), .din_valid(din_valid), .din_ready(din_ready_a),
    .mul_start(mul_start_a), .mul_done(mul_done), .addra(addra_a), .addrb(addrb_a),
    .addrw(addrw_a), .we(we_a), .d_in(d_in_a), .INS(ins_a), .busy(busy_a), .err(err_a)
  );

  ins_seq #(.ADDR_W(W), .ALU_LAT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(ins_ready_b),
    .ins_word(ins_word), .din_valid(din_valid), .din_ready(din_ready_b),
    .mul_start(mul_start_b), .mul_done(mul_done), .addra(addra_b), .addrb(addrb_b),
    .addrw(addrw_b), .we(we_b), .d_in(d_in_b), .INS(ins_b), .busy(busy_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [W-1:0] dst,
                                       input logic [W-1:0] sa, input logic [W-1:0] sb);
    return {op, dst, sa, sb};
  endfunction

  function automatic logic [31:0] outs_a();
    return {4'd0, ins_ready_a, din_ready_a, mul_start_a, we_a, d_in_a, ins_a,
            addra_a, addrb_a, addrw_a, busy_a, err_a};
  endfunction

  typedef struct {
    logic [2:0] op;
    logic [W-1:0] dst, sa, sb;
    int dly;    // cycles the din/mul handshake is withheld
    bit hold;   // mul_done held high rather than pulsed
    bit noise;  // din_valid and mul_done forced high throughout
    int lat2;   // accept edge to we cycle, ALU_LAT=2
    int lat4;   // same, ALU_LAT=4
    int mst;    // expected mul_start pulses
    int drdy;   // expected din_ready cycles
  } vec_t;

  vec_t tbl[9];

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    int lat_a, lat_b, wec_a, wec_b, mst_a, mst_b, drdy, rdy_a, rdy_b;
    logic [2:0] ins_at;
    logic din_at, busy1;
    logic [W-1:0] aw_at, aa_at, ab_at;
    lat_a = 0; lat_b = 0; wec_a = 0; wec_b = 0; mst_a = 0; mst_b = 0;
    drdy = 0; rdy_a = 0; rdy_b = 0; ins_at = '0; din_at = 1'b0; busy1 = 1'b0;
    aw_at = '0; aa_at = '0; ab_at = '0;
    ins_word  = mk(v.op, v.dst, v.sa, v.sb);
    ins_valid = 1'b1;
    check($sformatf("v%0d_ready_before", idx), {31'd0, ins_ready_a}, 32'd1);
    step();
    ins_valid = 1'b0;
    ins_word  = '1;
    for (k = 1; k <= 60; k++) begin
      din_valid = v.noise || (v.op == 3'd1 && k == 1 + v.dly);
      mul_done  = v.noise || (v.op == 3'd5 && (v.hold ? (k >= 2 + v.dly) : (k == 2 + v.dly)));
      if (k == 1) busy1 = busy_a;
      if (we_a) begin
        wec_a++;
        if (lat_a == 0) begin
          lat_a = k; ins_at = ins_a; din_at = d_in_a;
          aw_at = addrw_a; aa_at = addra_a; ab_at = addrb_a;
        end
      end
      if (we_b) begin
        wec_b++;
        if (lat_b == 0) lat_b = k;
      end
      if (mul_start_a) mst_a++;
      if (mul_start_b) mst_b++;
      if (din_ready_a) drdy++;
      if (ins_ready_a && rdy_a == 0) rdy_a = k;
      if (ins_ready_b && rdy_b == 0) rdy_b = k;
      if (rdy_a != 0 && rdy_b != 0) break;
      step();
    end
    din_valid = 1'b0;
    mul_done  = 1'b0;
    check($sformatf("v%0d_completed", idx), {31'd0, (rdy_a != 0 && rdy_b != 0)}, 32'd1);
    check($sformatf("v%0d_busy", idx), {31'd0, busy1}, 32'd1);
    check($sformatf("v%0d_lat_a", idx), lat_a, v.lat2);
    check($sformatf("v%0d_lat_b", idx), lat_b, v.lat4);
    check($sformatf("v%0d_we_cnt_a", idx), wec_a, 1);
    check($sformatf("v%0d_we_cnt_b", idx), wec_b, 1);
    check($sformatf("v%0d_ready_cycle", idx), rdy_a, v.lat2 + 1);
    check($sformatf("v%0d_ins", idx), {29'd0, ins_at}, {29'd0, v.op});
    check($sformatf("v%0d_d_in", idx), {31'd0, din_at}, {31'd0, (v.op == 3'd1)});
    check($sformatf("v%0d_addrw", idx), aw_at, v.dst);
    check($sformatf("v%0d_addra", idx), aa_at, v.sa);
    check($sformatf("v%0d_addrb", idx), ab_at, v.sb);
    check($sformatf("v%0d_mul_start_a", idx), mst_a, v.mst);
    check($sformatf("v%0d_mul_start_b", idx), mst_b, v.mst);
    check($sformatf("v%0d_din_ready", idx), drdy, v.drdy);
    check($sformatf("v%0d_err", idx), {31'd0, err_a}, 32'd0);
  endtask

  initial begin
    int wec;
    //        op    dst    sa     sb    dly hold noise lat2 lat4 mst drdy
    tbl[0] = '{3'd2, 6'd5,  6'd9,  6'd0,  0, 0, 0, 3,  3,  0, 0};
    tbl[1] = '{3'd3, 6'd1,  6'd2,  6'd3,  0, 0, 0, 4,  6,  0, 0};
    tbl[2] = '{3'd4, 6'd7,  6'd10, 6'd11, 0, 0, 0, 4,  6,  0, 0};
    tbl[3] = '{3'd5, 6'd12, 6'd13, 6'd14, 10, 0, 0, 13, 13, 1, 0};
    tbl[4] = '{3'd5, 6'd63, 6'd0,  6'd63, 0, 1, 0, 3,  3,  1, 0};
    tbl[5] = '{3'd1, 6'd20, 6'd21, 6'd22, 5, 0, 0, 7,  7,  0, 6};
    tbl[6] = '{3'd1, 6'd0,  6'd1,  6'd2,  0, 0, 0, 2,  2,  0, 1};
    tbl[7] = '{3'd2, 6'd33, 6'd33, 6'd40, 0, 0, 0, 3,  3,  0, 0};
    tbl[8] = '{3'd3, 6'd4,  6'd5,  6'd6,  0, 0, 1, 4,  6,  0, 0};

    step();
    step();
    check("reset_outputs", outs_a(), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_reset_ready", {31'd0, ins_ready_a}, 32'd1);
    check("post_reset_busy", {31'd0, busy_a}, 32'd0);
    check("post_reset_ins", {29'd0, ins_a}, 32'd0);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // illegal opcode then NOP, back to back
    ins_word  = mk(3'd7, 6'd1, 6'd2, 6'd3);
    ins_valid = 1'b1;
    step();
    check("illegal_err", {31'd0, err_a}, 32'd1);
    check("illegal_stays_idle", {31'd0, busy_a}, 32'd0);
    ins_word = mk(3'd0, 6'd9, 6'd9, 6'd9);
    step();
    ins_valid = 1'b0;
    wec = 0;
    for (int c = 0; c < 4; c++) begin
      if (we_a) wec++;
      step();
    end
    check("nop_err_sticky", {31'd0, err_a}, 32'd1);
    check("nop_no_we", wec, 0);
    check("nop_ready", {31'd0, ins_ready_a}, 32'd1);
    check("nop_addra_kept", addra_a, tbl[8].sa);
    check("nop_addrw_kept", addrw_a, tbl[8].dst);

    // reset while a MUL waits for mul_done
    ins_word  = mk(3'd5, 6'd2, 6'd3, 6'd4);
    ins_valid = 1'b1;
    step();
    ins_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("mul_wait_busy", {31'd0, busy_a}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", outs_a(), 32'd0);
    step();
    rst_n    = 1'b1;
    mul_done = 1'b1;
    wec = 0;
    for (int c = 0; c < 5; c++) begin
      if (we_a || we_b) wec++;
      step();
    end
    mul_done = 1'b0;
    check("midreset_no_we", wec, 0);
    check("midreset_err_cleared", {31'd0, err_a}, 32'd0);
    check("midreset_ready", {31'd0, ins_ready_a}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ins_seq.md
Name: ins_seq

Overview:
- Instruction sequencer driving the 40-bit operand-select mux (`d_in`, `INS`) and the working-register RAM of the cryptoprocessor datapath.
- Accepts one instruction at a time over a valid/ready handshake and issues RAM read addresses.
- Waits out adder/subtractor latency or handshakes with the multiplier, then performs a single-cycle write-back of the mux output to the destination address.
- Non-pipelined: one instruction in flight.

Parameters:
- ADDR_W, 6, working-RAM address width.
- ALU_LAT, 2, add/sub result latency in cycles after the operand read completes (legal range 1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ins_valid  in  1  instruction word present.
- ins_ready  out  1  sequencer accepts instruction this cycle.
- ins_word  in  3+3*ADDR_W  {op[2:0], dst, srcA, srcB}; op is the MSBs.
- din_valid  in  1  external data word valid (LOAD operand).
- din_ready  out  1  external word consumed this cycle.
- mul_start  out  1  one-cycle multiplier start pulse.
- mul_done  in  1  multiplier result valid (level or pulse).
- addra  out  ADDR_W  RAM port A read address.
- addrb  out  ADDR_W  RAM port B read address.
- addrw  out  ADDR_W  RAM write address.
- we  out  1  RAM write enable.
- d_in  out  1  mux external-load select.
- INS  out  3  mux source select.
- busy  out  1  instruction in flight.
- err  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; counter 0.
  - All outputs 0, including ins_ready, din_ready, mul_start, we, d_in, INS, addresses, busy and err.
  - Reset mid-instruction abandons it with no write.
- Opcodes: 0 NOP; 1 LOAD (external din); 2 MOV (RAM port A); 3 ADD; 4 SUB; 5 MUL; 6 and 7 are illegal.
- ins_ready = (state==IDLE) and rst_n deasserted. An instruction is accepted on the edge where ins_valid && ins_ready; fields are latched.
- IDLE:
  - op0: consumed, stay IDLE, no outputs change.
  - op6/7: consumed, err<=1 (sticky until reset), stay IDLE.
  - op1: go to DIN.
  - op2-5: go to RD.
- DIN:
  - INS=1, d_in=1, din_ready=1.
  - When din_valid=1, go to WB; the handshake completes that cycle.
  - Otherwise wait indefinitely.
- RD (1 cycle): addra=srcA, addrb=srcB; both are held stable through EX and WB. Go to EX.
- EX, by opcode (INS=op throughout):
  - op2: 1 cycle, then WB.
  - op3/4: count ALU_LAT cycles, then WB.
  - op5: mul_start=1 in the first EX cycle only. Wait for mul_done=1; a mul_done already high in the first EX cycle counts. Then WB.
- WB (1 cycle):
  - we=1, addrw=dst.
  - INS=op; d_in=1 only for op1.
  - Go to IDLE; ins_ready is 1 in the following cycle.
- INS=0 and d_in=0 in IDLE.
- busy=1 in every state except IDLE.
- All outputs are registered or decoded from registered state only; no combinational input-to-output paths except the rst_n gate on ins_ready.
- Instruction latency, accept edge to we cycle inclusive:
  - MOV = 3 cycles.
  - ADD/SUB = 2+ALU_LAT cycles.
  - LOAD = 2 cycles plus din wait.
  - MUL = 3 cycles plus mul_done wait.
- Back-to-back: a new instruction can be accepted on the edge after WB; there is no overlap.
- mul_done or din_valid asserted outside the relevant state is ignored.
- srcA==dst is legal: the read completes before WB.

Test Plan:
- Reset → all outputs 0. Release rst_n → ins_ready=1, busy=0, INS=0.
- MOV: ins_word op=2, dst=5, srcA=9 → addra=9 in RD; one EX cycle; we=1, addrw=5, INS=2 exactly 3 cycles after accept; then ins_ready=1.
- ADD: op=3, dst=1, srcA=2, srcB=3, ALU_LAT=2 → addra=2, addrb=3; INS=3 for 2 EX cycles; we at cycle 4. SUB with ALU_LAT=4 → we at cycle 6.
- MUL: op=5, mul_done delayed 10 cycles → exactly one mul_start pulse; we one cycle after mul_done with INS=5. Repeat with mul_done held high → still one start pulse, and only one write.
- LOAD: op=1, din_valid withheld 5 cycles → d_in=1, din_ready=1 held; we=1, d_in=1 in the cycle after din_valid.
- Illegal op=7, then NOP → err=1 and stays 1; no we pulse. Assert rst_n low during a MUL wait → IDLE, no write, err cleared.
